// File: rtl/multu_hilo_pkg.sv
// Shared definitions for the sequential HI/LO multiplier: default operand
// width and the controller state encoding.
package multu_hilo_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Plain-vector aliases of the enum so state registers stay simple logic.
  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_RUN  = S_RUN;
  localparam logic [1:0] ST_DONE = S_DONE;

endpackage

// File: rtl/multu_hilo_if.sv
// Operand, handshake and HI/LO access bundle between the control unit /
// execute stage (master) and the multiplier (slave).
interface multu_hilo_if #(
  parameter int WIDTH = multu_hilo_pkg::DEFAULT_WIDTH
);

  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             start;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             sel_hi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] dataOut;

  modport master (
    output dataA, dataB, start, hi_we, lo_we, wdata, sel_hi,
    input  busy, done, hi, lo, dataOut
  );

  modport slave (
    input  dataA, dataB, start, hi_we, lo_we, wdata, sel_hi,
    output busy, done, hi, lo, dataOut
  );

endinterface

// File: rtl/multu_hilo_hilo_reg.sv
// HI/LO register pair. A completing multiply loads both halves and overrides
// any MTHI/MTLO write in the same cycle; dataOut is gated to zero in reset.
module hilo_reg #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prod_we,
  input  logic [2*WIDTH-1:0] prod,
  input  logic               hi_we,
  input  logic               lo_we,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               sel_hi,
  output logic [WIDTH-1:0]   hi_reg,
  output logic [WIDTH-1:0]   lo_reg,
  output logic [WIDTH-1:0]   data_out
);

  // Register update: reset, then product load, then independent MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (prod_we) begin
      hi_reg <= prod[2*WIDTH-1:WIDTH];
      lo_reg <= prod[WIDTH-1:0];
    end else begin
      if (hi_we) hi_reg <= wdata;
      if (lo_we) lo_reg <= wdata;
    end
  end

  // Read mux, forced to zero while reset is held so the ALU sees a clean 0.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out
    assign data_out[gi] = ~reset & (sel_hi ? hi_reg[gi] : lo_reg[gi]);
  end

endmodule

// File: rtl/multu_hilo.sv
// Sequential unsigned shift-add multiplier: one partial product per cycle,
// fixed ITER-cycle latency, result delivered straight into HI/LO.
module multu_hilo
  import multu_hilo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ITER  = WIDTH
) (
  input logic       clk,
  input logic       reset,
  multu_hilo_if.slave bus
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  logic [1:0]         state_reg, state_next;
  logic [2*WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [2*WIDTH-1:0] product_reg, product_next;
  logic [CW-1:0]      count_reg, count_next;
  logic [2*WIDTH-1:0] sum;
  logic               prod_we;
  logic [WIDTH-1:0]   hi_w, lo_w, data_out_w;

  // Next-state and datapath: load operands in IDLE, accumulate in RUN; the
  // last accumulation bypasses product_reg and lands directly in HI/LO.
  always_comb begin
    state_next   = state_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    product_next = product_reg;
    count_next   = count_reg;
    prod_we      = 1'b0;
    sum          = product_reg + (mplier_reg[0] ? mcand_reg : '0);
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          mcand_next   = {{WIDTH{1'b0}}, bus.dataA};
          mplier_next  = bus.dataB;
          product_next = '0;
          count_next   = '0;
          state_next   = ST_RUN;
        end
      end
      ST_RUN: begin
        product_next = sum;
        mcand_next   = mcand_reg << 1;
        mplier_next  = mplier_reg >> 1;
        count_next   = count_reg + CW'(1);
        if (count_reg == CW'(ITER - 1)) begin
          prod_we    = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      product_reg <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      product_reg <= product_next;
      count_reg   <= count_next;
    end
  end

  hilo_reg #(
    .WIDTH (WIDTH)
  ) u_hilo (
    .clk      (clk),
    .reset    (reset),
    .prod_we  (prod_we),
    .prod     (sum),
    .hi_we    (bus.hi_we),
    .lo_we    (bus.lo_we),
    .wdata    (bus.wdata),
    .sel_hi   (bus.sel_hi),
    .hi_reg   (hi_w),
    .lo_reg   (lo_w),
    .data_out (data_out_w)
  );

  assign bus.busy    = (state_reg == ST_RUN);
  assign bus.done    = (state_reg == ST_DONE);
  assign bus.hi      = hi_w;
  assign bus.lo      = lo_w;
  assign bus.dataOut = data_out_w;

endmodule

// File: tb/tb_multu_hilo.sv
// Bench for multu_hilo: directed multiplies with hand-computed products are
// queued by the stimulus; a monitor pops and checks on every done pulse.
module tb_multu_hilo;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multu_hilo_if #(.WIDTH(W)) bus ();

  multu_hilo #(
    .WIDTH (W),
    .ITER  (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   done_count = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one multiply (start for a single accepting edge) and queue its result.
  task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    exp_t e;
    e.hi = exp_hi;
    e.lo = exp_lo;
    exp_q.push_back(e);
    bus.dataA = a;
    bus.dataB = b;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  // Monitor: measures the busy run length and checks each completion.
  initial begin
    int   run_len;
    logic prev_done;
    exp_t e;
    run_len   = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        run_len = 0;
      end else if (bus.busy) begin
        run_len++;
      end else if (bus.done) begin
        done_count++;
        check("busy_len", W'(run_len), W'(32));
        check("done_width", W'(prev_done), '0);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: hi=0x%08h lo=0x%08h required no pulse", bus.hi, bus.lo);
        end else begin
          e = exp_q.pop_front();
          check("prod_hi", bus.hi, e.hi);
          check("prod_lo", bus.lo, e.lo);
          check("prod_dataOut", bus.dataOut, bus.sel_hi ? e.hi : e.lo);
          $display("done #%0d hi=0x%08h lo=0x%08h", done_count, bus.hi, bus.lo);
        end
        run_len = 0;
      end else begin
        run_len = 0;
      end
      prev_done = bus.done;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    bus.dataA  = '0;
    bus.dataB  = '0;
    bus.start  = 1'b0;
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b0;
    bus.wdata  = '0;
    bus.sel_hi = 1'b0;
    reset      = 1'b1;

    // Reset state
    cyc(2);
    check("rst_hi", bus.hi, '0);
    check("rst_lo", bus.lo, '0);
    check("rst_dataOut", bus.dataOut, '0);
    check("rst_busy", W'(bus.busy), '0);
    check("rst_done", W'(bus.done), '0);

    // MTHI then reset: dataOut gated to 0 combinationally
    reset = 1'b0;
    bus.sel_hi = 1'b1;
    bus.hi_we  = 1'b1;
    bus.wdata  = 32'h0000ABCD;
    cyc(1);
    bus.hi_we = 1'b0;
    check("mthi_dataOut", bus.dataOut, 32'h0000ABCD);
    reset = 1'b1;
    #1;
    check("rst_gate_hi", bus.hi, 32'h0000ABCD);
    check("rst_gate_dataOut", bus.dataOut, '0);
    cyc(1);
    check("rst_clear_hi", bus.hi, '0);
    reset = 1'b0;

    // Both enables together
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h5A5A0FF0;
    cyc(1);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("both_we_hi", bus.hi, 32'h5A5A0FF0);
    check("both_we_lo", bus.lo, 32'h5A5A0FF0);

    // 3*5; operands changed after acceptance must not matter
    bus.sel_hi = 1'b0;
    mul(32'd3, 32'd5, 32'h0, 32'h0000000F);
    check("busy_after_accept", W'(bus.busy), W'(1));
    check("run_reads_old_lo", bus.dataOut, 32'h5A5A0FF0);
    bus.dataA = 32'hFFFFFFFF;
    bus.dataB = 32'hFFFFFFFF;
    cyc(40);

    // Extremes
    mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    cyc(40);
    bus.sel_hi = 1'b1;
    mul(32'h80000000, 32'd2, 32'h00000001, 32'h00000000);
    cyc(40);

    // start held 80 cycles: accepts at n, n+34, n+68
    bus.sel_hi = 1'b0;
    d0 = done_count;
    mul(32'd7, 32'd6, 32'h0, 32'd42);
    exp_q.push_back('{hi: 32'h0, lo: 32'd42});
    exp_q.push_back('{hi: 32'h0, lo: 32'd42});
    bus.start = 1'b1;
    cyc(79);
    bus.start = 1'b0;
    cyc(40);
    check("held_start_dones", W'(done_count - d0), W'(3));

    // Reset at RUN cycle 10: abort, clear, no done
    bus.dataA = 32'h12345678;
    bus.dataB = 32'h00000010;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(9);
    check("pre_abort_busy", W'(bus.busy), W'(1));
    reset = 1'b1;
    cyc(1);
    check("abort_busy", W'(bus.busy), '0);
    check("abort_done", W'(bus.done), '0);
    check("abort_hi", bus.hi, '0);
    check("abort_lo", bus.lo, '0);
    check("abort_dataOut", bus.dataOut, '0);
    reset = 1'b0;
    d0 = done_count;
    cyc(40);
    check("abort_no_done", W'(done_count - d0), '0);

    // MTHI during RUN visible until completion; MTLO on completion edge loses
    bus.sel_hi = 1'b1;
    mul(32'd2, 32'd3, 32'h0, 32'd6);
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEADBEEF;
    cyc(1);
    bus.hi_we = 1'b0;
    check("run_mthi_dataOut", bus.dataOut, 32'hDEADBEEF);
    cyc(29);
    check("run_mthi_late", bus.dataOut, 32'hDEADBEEF);
    cyc(1);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h11111111;
    cyc(1);
    bus.lo_we = 1'b0;
    check("collide_hi", bus.hi, 32'h0);
    check("collide_lo", bus.lo, 32'd6);
    cyc(3);

    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL pending_results: got %0d outstanding expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
